// File: rtl/ahb_pkg.sv
// Shared AHB 2.0 encodings and master FSM state constants for the single-master engine.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [1:0] RSP_OK        = 2'b00;
   localparam logic [1:0] RSP_BUS_ERR   = 2'b01;
   localparam logic [1:0] RSP_RETRY_EXH = 2'b10;

   typedef logic [2:0] mst_state_t;

   localparam mst_state_t ST_IDLE  = 3'd0;
   localparam mst_state_t ST_REQ   = 3'd1;
   localparam mst_state_t ST_ADDR  = 3'd2;
   localparam mst_state_t ST_DATA  = 3'd3;
   localparam mst_state_t ST_RESP2 = 3'd4;

endpackage

// File: rtl/ahb_single_master.sv
// AHB 2.0 bus-master engine: one command at a time, single NONSEQ word transfer,
// wait states, ERROR/RETRY/SPLIT handling and a one-cycle completion pulse.
module ahb_single_master
   import ahb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_RETRY = 4
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_status,
   output logic              HBUSREQ,
   input  logic              HGRANT,
   input  logic              HREADY,
   input  logic [1:0]        HRESP,
   input  logic [DATA_W-1:0] HRDATA,
   output logic [1:0]        HTRANS,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [DATA_W-1:0] HWDATA
);

   mst_state_t        state_q, state_d;
   logic [3:0]        retry_q, retry_d;
   logic              cwrite_q, cwrite_d;
   logic [ADDR_W-1:0] caddr_q, caddr_d;
   logic [DATA_W-1:0] cwdata_q, cwdata_d;
   logic [1:0]        rcode_q, rcode_d;
   logic              busreq_q, busreq_d;
   logic [1:0]        htrans_q, htrans_d;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic              hwrite_q, hwrite_d;
   logic [DATA_W-1:0] hwdata_q, hwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        rsp_status_q, rsp_status_d;

   logic              resp_fin;
   logic [1:0]        resp_code;
   logic [4:0]        retry_inc;

   always_comb begin
      state_d      = state_q;
      retry_d      = retry_q;
      cwrite_d     = cwrite_q;
      caddr_d      = caddr_q;
      cwdata_d     = cwdata_q;
      rcode_d      = rcode_q;
      busreq_d     = busreq_q;
      htrans_d     = htrans_q;
      haddr_d      = haddr_q;
      hwrite_d     = hwrite_q;
      hwdata_d     = hwdata_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_status_d = rsp_status_q;
      resp_fin     = 1'b0;
      resp_code    = rcode_q;
      retry_inc    = {1'b0, retry_q} + 5'd1;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               cwrite_d = cmd_write;
               caddr_d  = cmd_addr;
               cwdata_d = cmd_wdata;
               retry_d  = '0;
               busreq_d = 1'b1;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (HGRANT && HREADY) begin
               htrans_d = HTRANS_NONSEQ;
               haddr_d  = caddr_q;
               hwrite_d = cwrite_q;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               htrans_d = HTRANS_IDLE;
               busreq_d = 1'b0;
               if (cwrite_q) hwdata_d = cwdata_q;
               state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (HRESP == HRESP_OKAY) begin
               if (HREADY) begin
                  rsp_valid_d  = 1'b1;
                  rsp_status_d = RSP_OK;
                  if (!cwrite_q) rsp_rdata_d = HRDATA;
                  state_d      = ST_IDLE;
               end
            end else if (HREADY) begin
               // Slave skipped the first response cycle: act on it as the second one.
               resp_fin  = 1'b1;
               resp_code = HRESP;
            end else begin
               rcode_d = HRESP;
               state_d = ST_RESP2;
            end
         end
         ST_RESP2: begin
            if (HREADY) resp_fin = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (resp_fin) begin
         if (resp_code == HRESP_ERROR) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = RSP_BUS_ERR;
            state_d      = ST_IDLE;
         end else begin
            // 5-bit compare so MAX_RETRY=15 cannot wrap the counter back to zero.
            retry_d = retry_inc[3:0];
            if (retry_inc <= 5'(MAX_RETRY)) begin
               busreq_d = 1'b1;
               state_d  = ST_REQ;
            end else begin
               rsp_valid_d  = 1'b1;
               rsp_status_d = RSP_RETRY_EXH;
               state_d      = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= ST_IDLE;
         retry_q      <= '0;
         cwrite_q     <= 1'b0;
         caddr_q      <= '0;
         cwdata_q     <= '0;
         rcode_q      <= '0;
         busreq_q     <= 1'b0;
         htrans_q     <= HTRANS_IDLE;
         haddr_q      <= '0;
         hwrite_q     <= 1'b0;
         hwdata_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_status_q <= RSP_OK;
      end else begin
         state_q      <= state_d;
         retry_q      <= retry_d;
         cwrite_q     <= cwrite_d;
         caddr_q      <= caddr_d;
         cwdata_q     <= cwdata_d;
         rcode_q      <= rcode_d;
         busreq_q     <= busreq_d;
         htrans_q     <= htrans_d;
         haddr_q      <= haddr_d;
         hwrite_q     <= hwrite_d;
         hwdata_q     <= hwdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_status = rsp_status_q;
   assign HBUSREQ    = busreq_q;
   assign HTRANS     = htrans_q;
   assign HADDR      = haddr_q;
   assign HWRITE     = hwrite_q;
   assign HWDATA     = hwdata_q;
   assign HSIZE      = HSIZE_WORD;
   assign HBURST     = HBURST_SINGLE;

endmodule

// File: tb/tb_ahb_single_master.sv
// Bench for ahb_single_master: directed vector table, randomized transactions
// against a transaction-level model, and an asynchronous reset sequence.
module tb_ahb_single_master;
   import ahb_pkg::*;

   localparam int unsigned MAXR = 2;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        HBUSREQ, HGRANT, HREADY;
   logic [1:0]  HRESP, HTRANS;
   logic [31:0] HRDATA, HADDR, HWDATA;
   logic        HWRITE;
   logic [2:0]  HSIZE, HBURST;

   ahb_single_master #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(MAXR)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .HBUSREQ(HBUSREQ), .HGRANT(HGRANT), .HREADY(HREADY), .HRESP(HRESP),
      .HRDATA(HRDATA), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA)
   );

   always #5 HCLK = ~HCLK;

   int n_vec = 0;
   int n_err = 0;
   int n_issue_seen = 0;

   // Address phases actually accepted on the bus.
   always @(posedge HCLK)
      if (HRESETn && HTRANS == HTRANS_NONSEQ && HREADY) n_issue_seen <= n_issue_seen + 1;

   typedef struct {
      logic [1:0]  resp;
      int          g;
      int          a;
      int          w;
      bit          viol;
      logic [31:0] rdata;
   } att_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          g, a, w;
      bit          viol;
      logic [1:0]  r0, r1, r2;
      logic [31:0] rdata;
      logic [1:0]  exp_status;
      int          exp_issues;
      logic [31:0] exp_rdata;
   } vec_t;

   att_t        plan[3];
   vec_t        vecs[8];
   logic [31:0] m_rdata  = '0;
   logic [31:0] m_hwdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   // Outcome from the transfer rules: first OKAY or ERROR ends it; each RETRY/SPLIT
   // costs one retry, and exceeding MAXR retries reports exhaustion.
   function automatic void model_txn(input bit wr, output int issues,
                                     output logic [1:0] status, output logic [31:0] rdata);
      issues = 0;
      status = RSP_OK;
      rdata  = m_rdata;
      for (int k = 0; k < 3; k++) begin
         issues++;
         if (plan[k].resp == HRESP_OKAY) begin
            if (!wr) rdata = plan[k].rdata;
            return;
         end
         if (plan[k].resp == HRESP_ERROR) begin
            status = RSP_BUS_ERR;
            return;
         end
         if (issues > int'(MAXR)) begin
            status = RSP_RETRY_EXH;
            return;
         end
      end
   endfunction

   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int n_iss, input logic [1:0] e_stat, input logic [31:0] e_rdata);
      int base;
      int v;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      HGRANT    = 1'b0;
      HREADY    = 1'b1;
      HRESP     = HRESP_OKAY;
      chk("ready_before_accept", 32'(cmd_ready), 32'd1);
      step();
      base      = n_issue_seen;
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_write = 1'($urandom);
      chk("ready_low_after_accept", 32'(cmd_ready), 32'd0);
      for (int k = 0; k < n_iss; k++) begin
         chk("req_busreq", 32'(HBUSREQ), 32'd1);
         chk("req_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
         chk("req_no_rsp", 32'(rsp_valid), 32'd0);
         for (int i = 0; i < plan[k].g; i++) begin
            v = int'($urandom_range(0, 2));
            {HGRANT, HREADY} = 2'(v);
            HRDATA = $urandom;
            step();
            chk("req_wait_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
            chk("req_wait_busreq", 32'(HBUSREQ), 32'd1);
         end
         HGRANT = 1'b1;
         HREADY = 1'b1;
         step();
         chk("addr_nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
         chk("addr_haddr", HADDR, addr);
         chk("addr_hwrite", 32'(HWRITE), 32'(wr));
         for (int i = 0; i < plan[k].a; i++) begin
            HREADY = 1'b0;
            HGRANT = 1'($urandom);
            step();
            chk("addr_wait_nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
            chk("addr_wait_haddr", HADDR, addr);
         end
         HREADY = 1'b1;
         step();
         if (wr) m_hwdata = wdata;
         chk("data_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
         chk("data_busreq", 32'(HBUSREQ), 32'd0);
         chk("data_hwdata", HWDATA, m_hwdata);
         for (int i = 0; i < plan[k].w; i++) begin
            HREADY = 1'b0;
            HRESP  = HRESP_OKAY;
            HGRANT = 1'($urandom);
            HRDATA = $urandom;
            step();
            chk("wait_hwdata", HWDATA, m_hwdata);
            chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
         end
         if (plan[k].resp == HRESP_OKAY) begin
            HREADY = 1'b1;
            HRDATA = plan[k].rdata;
            step();
         end else begin
            if (!plan[k].viol) begin
               HREADY = 1'b0;
               HRESP  = plan[k].resp;
               HRDATA = $urandom;
               step();
               chk("resp1_no_rsp", 32'(rsp_valid), 32'd0);
            end
            HREADY = 1'b1;
            HRESP  = plan[k].resp;
            HRDATA = $urandom;
            step();
         end
         HRESP = HRESP_OKAY;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_status", 32'(rsp_status), 32'(e_stat));
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("idle_busreq", 32'(HBUSREQ), 32'd0);
      chk("idle_haddr_held", HADDR, addr);
      chk("issue_count", 32'(n_issue_seen - base), 32'(n_iss));
      m_rdata = e_rdata;
   endtask

   initial begin
      int          iss;
      logic [1:0]  st;
      logic [31:0] rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;

      vecs[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 2, 0, 0, 1'b0,
                  HRESP_OKAY, HRESP_OKAY, HRESP_OKAY, 32'h0, RSP_OK, 1, 32'h0};
      vecs[1] = '{1'b0, 32'h0000_0100, 32'h0, 0, 0, 3, 1'b0,
                  HRESP_OKAY, HRESP_OKAY, HRESP_OKAY, 32'h1234_5678, RSP_OK, 1, 32'h1234_5678};
      vecs[2] = '{1'b0, 32'h0000_0200, 32'h0, 0, 0, 0, 1'b0,
                  HRESP_ERROR, HRESP_OKAY, HRESP_OKAY, 32'h0, RSP_BUS_ERR, 1, 32'h1234_5678};
      vecs[3] = '{1'b1, 32'h0000_0300, 32'hA5A5_0001, 1, 0, 0, 1'b0,
                  HRESP_RETRY, HRESP_RETRY, HRESP_RETRY, 32'h0, RSP_RETRY_EXH, 3, 32'h1234_5678};
      vecs[4] = '{1'b0, 32'h0000_0400, 32'h0, 0, 1, 1, 1'b0,
                  HRESP_RETRY, HRESP_SPLIT, HRESP_OKAY, 32'hCAFE_F00D, RSP_OK, 3, 32'hCAFE_F00D};
      vecs[5] = '{1'b0, 32'h0000_0404, 32'h0, 0, 0, 0, 1'b1,
                  HRESP_ERROR, HRESP_OKAY, HRESP_OKAY, 32'h0, RSP_BUS_ERR, 1, 32'hCAFE_F00D};
      vecs[6] = '{1'b0, 32'h0000_0408, 32'h0, 3, 2, 0, 1'b0,
                  HRESP_SPLIT, HRESP_SPLIT, HRESP_SPLIT, 32'h0, RSP_RETRY_EXH, 3, 32'hCAFE_F00D};
      vecs[7] = '{1'b1, 32'h0000_0008, 32'h0BAD_F00D, 0, 2, 2, 1'b0,
                  HRESP_OKAY, HRESP_OKAY, HRESP_OKAY, 32'h0, RSP_OK, 1, 32'hCAFE_F00D};

      HRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      HGRANT    = 1'b0;
      HREADY    = 1'b1;
      HRESP     = HRESP_OKAY;
      HRDATA    = '0;
      #7;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busreq", 32'(HBUSREQ), 32'd0);
      chk("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_hsize", 32'(HSIZE), 32'(HSIZE_WORD));
      chk("rst_hburst", 32'(HBURST), 32'(HBURST_SINGLE));
      #5 HRESETn = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         plan[0] = '{vecs[i].r0, vecs[i].g, vecs[i].a, vecs[i].w, vecs[i].viol, vecs[i].rdata};
         plan[1] = '{vecs[i].r1, vecs[i].g, vecs[i].a, vecs[i].w, vecs[i].viol, vecs[i].rdata};
         plan[2] = '{vecs[i].r2, vecs[i].g, vecs[i].a, vecs[i].w, vecs[i].viol, vecs[i].rdata};
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_issues,
                 vecs[i].exp_status, vecs[i].exp_rdata);
      end

      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < 3; k++) begin
            plan[k].resp  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : HRESP_OKAY;
            plan[k].g     = int'($urandom_range(0, 3));
            plan[k].a     = int'($urandom_range(0, 2));
            plan[k].w     = int'($urandom_range(0, 3));
            plan[k].viol  = ($urandom_range(0, 3) == 0);
            plan[k].rdata = $urandom;
         end
         wr   = 1'($urandom);
         addr = $urandom & 32'hFFFF_FFFC;
         wd   = $urandom;
         model_txn(wr, iss, st, rd);
         run_txn(wr, addr, wd, iss, st, rd);
      end

      // Reset while a read sits in its data phase with wait states pending.
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0000_0500;
      HGRANT    = 1'b1;
      HREADY    = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      HREADY = 1'b0;
      step();
      step();
      chk("pre_rst_in_data", 32'(HTRANS), 32'(HTRANS_IDLE));
      #2 HRESETn = 1'b0;
      #1;
      chk("async_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("async_busreq", 32'(HBUSREQ), 32'd0);
      chk("async_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
      chk("async_haddr", HADDR, 32'h0);
      chk("async_hwrite", 32'(HWRITE), 32'd0);
      chk("async_hwdata", HWDATA, 32'h0);
      chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async_rsp_rdata", rsp_rdata, 32'h0);
      chk("async_rsp_status", 32'(rsp_status), 32'd0);
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      @(negedge HCLK);
      HRESETn = 1'b1;
      m_rdata  = '0;
      m_hwdata = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
         chk("post_rst_ready", 32'(cmd_ready), 32'd1);
      end

      plan[0] = '{HRESP_OKAY, 1, 0, 1, 1'b0, 32'h5555_AAAA};
      plan[1] = plan[0];
      plan[2] = plan[0];
      model_txn(1'b0, iss, st, rd);
      run_txn(1'b0, 32'h0000_0600, 32'h0, iss, st, rd);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
      $fatal(1);
   end

endmodule
